atm_session_driver: RTL

//  Customer-side initiator for the ATM core. Accepts one transaction request at a time over a valid/ready port.

---
 rtl/atm_session_driver.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/atm_session_driver.sv
// Customer-side session driver for the ATM core. It takes one host request at a time,
// sequences card, PIN and menu operation into the core, and returns one response word.
module atm_session_driver #(
  parameter int         TIMEOUT_CYC   = 16,
  parameter logic [2:0] ST_WAITING    = 3'd0,
  parameter logic [2:0] ST_AUTH       = 3'd1,
  parameter logic [2:0] ST_MENU       = 3'd2,
  parameter logic [2:0] OP_NOP        = 3'd0,
  parameter logic [2:0] OP_BALANCE    = 3'd1,
  parameter logic [2:0] OP_WITHDRAW   = 3'd2,
  parameter logic [2:0] OP_DEPOSIT    = 3'd3,
  parameter logic [2:0] OP_CHANGE_PIN = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_acc,
  input  logic [15:0] req_pin,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_amount,
  input  logic [15:0] req_newpin,
  output logic [3:0]  atm_acc_num,
  output logic [15:0] atm_pin,
  output logic [15:0] atm_newPin,
  output logic [31:0] atm_amount,
  output logic [2:0]  atm_operation,
  input  logic [2:0]  atm_state,
  input  logic        atm_success,
  input  logic [31:0] atm_balance,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_balance
);

  localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] RSP_OK        = 2'd0;
  localparam logic [1:0] RSP_AUTH_FAIL = 2'd1;
  localparam logic [1:0] RSP_OP_FAIL   = 2'd2;
  localparam logic [1:0] RSP_TIMEOUT   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CARD,
    S_AUTH,
    S_OP,
    S_EXEC,
    S_RSP
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_amount;
  logic [15:0]   r_newPin;
  logic [2:0]    r_op;

  logic w_accept;
  logic w_opValid;
  logic w_timeout;

  assign w_accept  = req_valid && req_ready;
  assign w_opValid = (req_op == OP_BALANCE)  || (req_op == OP_WITHDRAW) ||
                     (req_op == OP_DEPOSIT)  || (req_op == OP_CHANGE_PIN);
  // The wait timer expires on the cycle it has spent TIMEOUT_CYC cycles in one phase.
  assign w_timeout = (r_timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_amount      <= '0;
      r_newPin      <= '0;
      r_op          <= OP_NOP;
      req_ready     <= 1'b1;
      atm_acc_num   <= '0;
      atm_pin       <= '0;
      atm_newPin    <= '0;
      atm_amount    <= '0;
      atm_operation <= OP_NOP;
      rsp_valid     <= 1'b0;
      rsp_status    <= RSP_OK;
      rsp_balance   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            req_ready <= 1'b0;
            r_timer   <= '0;
            r_amount  <= req_amount;
            r_newPin  <= req_newpin;
            r_op      <= req_op;
            if (w_opValid) begin
              atm_acc_num <= req_acc;
              atm_pin     <= req_pin;
              r_state     <= S_CARD;
            end else begin
              // Unknown operations never reach the core.
              rsp_valid   <= 1'b1;
              rsp_status  <= RSP_OP_FAIL;
              rsp_balance <= '0;
              r_state     <= S_RSP;
            end
          end
        end

        S_CARD: begin
          if (atm_state == ST_AUTH) begin
            r_timer <= '0;
            r_state <= S_AUTH;
          end else if (w_timeout) begin
            r_timer     <= '0;
            rsp_valid   <= 1'b1;
            rsp_status  <= RSP_TIMEOUT;
            rsp_balance <= '0;
            r_state     <= S_RSP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_AUTH: begin
          if (atm_state == ST_MENU) begin
            r_timer    <= '0;
            atm_amount <= r_amount;
            atm_newPin <= r_newPin;
            r_state    <= S_OP;
          end else if (atm_state == ST_WAITING) begin
            r_timer     <= '0;
            rsp_valid   <= 1'b1;
            rsp_status  <= RSP_AUTH_FAIL;
            rsp_balance <= '0;
            r_state     <= S_RSP;
          end else if (w_timeout) begin
            r_timer     <= '0;
            rsp_valid   <= 1'b1;
            rsp_status  <= RSP_TIMEOUT;
            rsp_balance <= '0;
            r_state     <= S_RSP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_OP: begin
          // Operands are already stable; the operation code is presented for one cycle only.
          atm_operation <= r_op;
          r_timer       <= '0;
          r_state       <= S_EXEC;
        end

        S_EXEC: begin
          atm_operation <= OP_NOP;
          if (atm_state == ST_WAITING) begin
            r_timer     <= '0;
            rsp_valid   <= 1'b1;
            rsp_status  <= atm_success ? RSP_OK : RSP_OP_FAIL;
            rsp_balance <= atm_balance;
            r_state     <= S_RSP;
          end else if (w_timeout) begin
            r_timer     <= '0;
            rsp_valid   <= 1'b1;
            rsp_status  <= RSP_TIMEOUT;
            rsp_balance <= '0;
            r_state     <= S_RSP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_RSP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid   <= 1'b0;
            atm_acc_num <= '0;
            atm_pin     <= '0;
            atm_newPin  <= '0;
            atm_amount  <= '0;
            req_ready   <= 1'b1;
            r_timer     <= '0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
